instr_fetch_seq: RTL

- Two-byte instruction fetch sequencer sitting directly upstream of the instruction register and decode/execute datapath.
- Owns the program counter and reads the low byte then the high byte of each 16-bit instruction from byte-wide memory.
- Assembles the 16-bit instruction, splits it into fields, and offers it downstream with a valid/ready handshake.
- Supports a jump redirect from the execute stage.

---
 rtl/instr_fetch_seq_pkg.sv | 21 ++
 rtl/instr_field_split.sv | 21 ++
 rtl/instr_fetch_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the two-byte instruction fetch sequencer.
// Holds the fetch state encoding and the bit positions of the instruction fields.
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoReq,
    StLoWait,
    StHiReq,
    StHiWait,
    StHold
  } fetch_state_e;

  // Instruction layout: [15:12] opcode, [11:10] dst, [9:8] src, [7:0] immediate
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DST_LSB = 10;
  localparam int unsigned SRC_LSB = 8;
  localparam int unsigned IMM_MSB = 7;

endpackage

// File: rtl/instr_field_split.sv
// Pure combinational slicer of a 16-bit instruction into its decode fields.
// Shared with the decoder so both agree on the field layout.
module instr_field_split
  import instr_fetch_seq_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [1:0]  dst_sel,
  output logic [1:0]  src_sel,
  output logic [7:0]  imm
);

  // Fixed bit slices; no logic beyond wiring
  always_comb begin
    opcode  = ir[OPC_MSB:OPC_LSB];
    dst_sel = ir[DST_LSB+1:DST_LSB];
    src_sel = ir[SRC_LSB+1:SRC_LSB];
    imm     = ir[IMM_MSB:0];
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Two-byte instruction fetch sequencer: owns the PC, reads low then high byte from
// byte-wide memory, and offers the assembled instruction with a valid/ready handshake.
// A jump redirect from execute overrides every other transition.
// Optional feature: define INSTR_COUNT_EN to add a saturating 16-bit accepted-instruction
// counter on output icount.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned    AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_data,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [15:0]   ir_out,
  output logic [3:0]    opcode,
  output logic [1:0]    dst_sel,
  output logic [1:0]    src_sel,
  output logic [7:0]    imm,
  output logic [AW-1:0] pc
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]   icount
`endif
);

  localparam logic [AW-1:0] PcOne = AW'(1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic          handshake;

  // State, PC and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC advance and byte capture; a jump overrides all of it
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_en) state_d = StLoReq;
      end
      StLoReq: begin
        pc_d    = pc_q + PcOne;
        state_d = StLoWait;
      end
      StLoWait: begin
        ir_d[7:0] = mem_data;
        state_d   = StHiReq;
      end
      StHiReq: begin
        pc_d    = pc_q + PcOne;
        state_d = StHiWait;
      end
      StHiWait: begin
        ir_d[15:8] = mem_data;
        state_d    = StHold;
      end
      StHold: begin
        if (ir_ready) state_d = fetch_en ? StLoReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (jmp_valid) begin
      // Discard any in-flight byte and restart at the target
      pc_d    = jmp_addr;
      ir_d    = ir_q;
      state_d = fetch_en ? StLoReq : StIdle;
    end
  end

  // Memory strobe and handshake outputs decoded from the current state
  always_comb begin
    mem_rd    = (state_q == StLoReq) || (state_q == StHiReq);
    mem_addr  = pc_q;
    ir_valid  = (state_q == StHold);
    handshake = ir_valid && ir_ready;
    ir_out    = ir_q;
    pc        = pc_q;
  end

  instr_field_split u_field_split (
    .ir      (ir_q),
    .opcode  (opcode),
    .dst_sel (dst_sel),
    .src_sel (src_sel),
    .imm     (imm)
  );

`ifdef INSTR_COUNT_EN
  logic [15:0] icount_q;

  // Count accepted instructions, saturating; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icount_q <= '0;
    end else if (handshake && (icount_q != 16'hFFFF)) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign icount = icount_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
